// File: rtl/dm_port_arbiter_pkg.sv
// Shared constants for the data-RAM port arbiter: FSM encoding, port indices
// and the byte-enable width helper.
package dm_port_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic PORT_MEM = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int DATA_W_DEF = 32;
    localparam int WEN_W      = DATA_W_DEF / 8;

    function automatic int wen_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dm_port_arbiter_rr_pick2.sv
// Two-requester round-robin picker; optionally masks one port so the port
// just served cannot win again in the same cycle.
module rr_pick2
    import dm_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       excl_en,
    input  logic       excl,
    output logic       gnt,
    output logic       valid
);

    logic [1:0] elig;

    always_comb begin
        elig = req;
        if (excl_en) begin
            elig[excl] = 1'b0;
        end
        valid = |elig;
        gnt   = (elig == 2'b11) ? ~last : elig[PORT_DBG];
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Arbitrates the single-port, synchronous-read data RAM between the MEM stage
// (port 0) and the debug inspection path (port 1) with an ACC/RESP sequence.
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                m0_req,
    input  logic [DATA_W/8-1:0] m0_wen,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_done,
    input  logic                m1_req,
    input  logic [DATA_W/8-1:0] m1_wen,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_done,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W/8-1:0] ram_wen,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic                busy,
    output logic [CNT_W-1:0]    contention_cnt
);

    localparam int NB = wen_width(DATA_W);

    logic [1:0]        state, state_n;
    logic              gnt, gnt_n;
    logic              last, last_n;
    logic              acc, resp;
    logic              pick_gnt, pick_valid;
    logic              waiting;
    logic [DATA_W-1:0] hold0, hold1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign acc  = (state == ST_ACC);
    assign resp = (state == ST_RESP);
    assign busy = acc | resp;

    rr_pick2 u_pick (
        .req     ({m1_req, m0_req}),
        .last    (last),
        .excl_en (resp),
        .excl    (gnt),
        .gnt     (pick_gnt),
        .valid   (pick_valid)
    );

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        last_n  = last;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_n = ST_ACC;
                    gnt_n   = pick_gnt;
                end
            end
            ST_ACC: begin
                state_n = ST_RESP;
            end
            ST_RESP: begin
                last_n = gnt;
                if (pick_valid) begin
                    state_n = ST_ACC;
                    gnt_n   = pick_gnt;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // RAM is driven only during ACC; it samples at the end of that cycle.
    always_comb begin
        ram_addr  = '0;
        ram_wen   = '0;
        ram_wdata = '0;
        if (acc) begin
            if (gnt == PORT_DBG) begin
                ram_addr  = m1_addr;
                ram_wen   = m1_wen[NB-1:0];
                ram_wdata = m1_wdata;
            end else begin
                ram_addr  = m0_addr;
                ram_wen   = m0_wen[NB-1:0];
                ram_wdata = m0_wdata;
            end
        end
    end

    assign m0_done  = resp && (gnt == PORT_MEM);
    assign m1_done  = resp && (gnt == PORT_DBG);
    assign m0_rdata = m0_done ? ram_rdata : hold0;
    assign m1_rdata = m1_done ? ram_rdata : hold1;

    // In IDLE only a tie leaves a loser; otherwise the non-granted port waits.
    assign waiting = (state == ST_IDLE) ? (m0_req & m1_req)
                                        : ((gnt == PORT_MEM) ? m1_req : m0_req);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            gnt            <= PORT_MEM;
            last           <= PORT_DBG;
            hold0          <= '0;
            hold1          <= '0;
            contention_cnt <= '0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            last  <= last_n;
            if (m0_done) begin
                hold0 <= ram_rdata;
            end
            if (m1_done) begin
                hold1 <= ram_rdata;
            end
            if (waiting) begin
                contention_cnt <= sat_inc(contention_cnt);
            end
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed scenarios plus random traffic, checked
// cycle by cycle against a transaction-level model of the arbiter and RAM.
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_req, m1_req;
    logic [3:0]  m0_wen, m1_wen;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_done, m1_done;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_wen;
    logic        busy;
    logic [15:0] cnt;

    logic [31:0] s_m0_rdata, s_m1_rdata, s_ram_addr, s_ram_wdata;
    logic        s_m0_done, s_m1_done, s_busy;
    logic [3:0]  s_ram_wen;
    logic [3:0]  s_cnt;

    always #5 clk = ~clk;

    dm_port_arbiter dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_done(m0_done),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_done(m1_done),
        .ram_addr(ram_addr), .ram_wen(ram_wen), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy), .contention_cnt(cnt)
    );

    dm_port_arbiter #(.CNT_W(4)) dut4 (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(s_m0_rdata), .m0_done(s_m0_done),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(s_m1_rdata), .m1_done(s_m1_done),
        .ram_addr(s_ram_addr), .ram_wen(s_ram_wen), .ram_wdata(s_ram_wdata), .ram_rdata(ram_rdata),
        .busy(s_busy), .contention_cnt(s_cnt)
    );

    // Synchronous-read, byte-writable RAM driven by the main instance.
    logic [31:0] ram_mem [0:255];
    always @(posedge clk) begin
        ram_rdata <= ram_mem[ram_addr[9:2]];
        for (int b = 0; b < 4; b++) begin
            if (ram_wen[b]) ram_mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: which port is being served (-1 none), whether it is in
    // its address or response cycle, whose turn it is on a tie, waiting count.
    logic [31:0] gold [0:255];
    int          mcur, mph, mlast, mcnt;
    logic [31:0] mhold [2];
    bit          mok [2];
    bit          served [2];
    bit          auto_drop;

    function automatic logic preq(input int p);
        return (p == 1) ? m1_req : m0_req;
    endfunction
    function automatic logic [3:0] pwen(input int p);
        return (p == 1) ? m1_wen : m0_wen;
    endfunction
    function automatic logic [31:0] paddr(input int p);
        return (p == 1) ? m1_addr : m0_addr;
    endfunction
    function automatic logic [31:0] pwdata(input int p);
        return (p == 1) ? m1_wdata : m0_wdata;
    endfunction
    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] we);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        mcur = -1; mph = 0; mlast = 1; mcnt = 0;
        mhold[0] = 0; mhold[1] = 0; mok[0] = 1; mok[1] = 1;
        served[0] = 0; served[1] = 0;
    endtask

    task automatic eval();
        logic [3:0]  ew;
        logic [31:0] ea, ed;
        bit          edn [2];
        bit          w;
        int          oth, ec;
        logic [7:0]  idx;
        @(negedge clk);
        ew = 0; ea = 0; ed = 0;
        if (mcur >= 0 && mph == 0) begin
            ew = pwen(mcur); ea = paddr(mcur); ed = pwdata(mcur);
        end
        edn[0] = (mcur == 0 && mph == 1);
        edn[1] = (mcur == 1 && mph == 1);
        ec = (mcnt > 65535) ? 65535 : mcnt;
        chk("busy", busy, mcur >= 0);
        chk("ram_wen", ram_wen, ew);
        chk("ram_addr", ram_addr, ea);
        chk("ram_wdata", ram_wdata, ed);
        chk("m0_done", m0_done, edn[0]);
        chk("m1_done", m1_done, edn[1]);
        chk("cnt", cnt, ec);
        chk("cnt4", s_cnt, (mcnt > 15) ? 15 : mcnt);
        chk("cnt4_done0", s_m0_done, edn[0]);
        for (int p = 0; p < 2; p++) begin
            idx = paddr(p) >> 2;
            if (edn[p]) begin
                if (pwen(p) == 0) chk(p ? "m1_rdata_rd" : "m0_rdata_rd", p ? m1_rdata : m0_rdata, gold[idx]);
            end else if (mok[p]) begin
                chk(p ? "m1_rdata_hold" : "m0_rdata_hold", p ? m1_rdata : m0_rdata, mhold[p]);
            end
        end
        w = 0;
        if (mcur < 0) begin
            w = m0_req && m1_req;
            if (m0_req || m1_req) begin
                mcur = (m0_req && m1_req) ? 1 - mlast : (m0_req ? 0 : 1);
                mph  = 0;
            end
        end else begin
            oth = 1 - mcur;
            w   = preq(oth);
            idx = paddr(mcur) >> 2;
            if (mph == 0) begin
                gold[idx] = merge(gold[idx], pwdata(mcur), pwen(mcur));
                mph = 1;
            end else begin
                if (pwen(mcur) == 0) begin
                    mhold[mcur] = gold[idx]; mok[mcur] = 1;
                end else begin
                    mok[mcur] = 0;
                end
                mlast = mcur;
                if (preq(oth)) begin mcur = oth; mph = 0; end
                else mcur = -1;
            end
        end
        if (w) mcnt++;
        served[0] = edn[0];
        served[1] = edn[1];
    endtask

    task automatic nxt();
        @(posedge clk); #1;
        if (auto_drop) begin
            if (served[0]) m0_req = 0;
            if (served[1]) m1_req = 0;
        end
        served[0] = 0; served[1] = 0;
    endtask

    task automatic issue(input int p, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 1) begin m1_req = 1; m1_wen = wen; m1_addr = addr; m1_wdata = wdata; end
        else        begin m0_req = 1; m0_wen = wen; m0_addr = addr; m0_wdata = wdata; end
    endtask

    task automatic do_reset();
        m0_req = 0; m1_req = 0;
        resetn = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ram_wen", ram_wen, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_m0_done", m0_done, 0);
        chk("rst_m1_done", m1_done, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_cnt4", s_cnt, 0);
        resetn = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old;
        logic [3:0]  rw;
        int          nd, lastc, cyc;
        resetn = 0;
        m0_req = 0; m0_wen = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_wen = 0; m1_addr = 0; m1_wdata = 0;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
            gold[i]    = ram_mem[i];
        end
        ram_mem[1] = 32'hDEAD_BEEF;
        gold[1]    = 32'hDEAD_BEEF;
        auto_drop  = 1;

        // single read of 0x4
        do_reset();
        issue(0, 4'h0, 32'h4, 32'h0);
        eval(); chk("rd_c0_m1done", m1_done, 0);
        nxt(); eval(); chk("rd_c1_addr", ram_addr, 32'h4); chk("rd_c1_m1done", m1_done, 0);
        nxt(); eval(); chk("rd_c2_done", m0_done, 1); chk("rd_c2_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("rd_c2_m1done", m1_done, 0);
        nxt(); eval(); chk("rd_c3_done", m0_done, 0);

        // byte write then read back
        nxt(); issue(0, 4'b0100, 32'h10, 32'h00AB_0000);
        eval(); chk("bw_c0_wen", ram_wen, 0);
        nxt(); eval(); chk("bw_c1_wen", ram_wen, 4'b0100);
        nxt(); eval(); chk("bw_c2_done", m0_done, 1); chk("bw_c2_wen", ram_wen, 0);
        nxt(); issue(0, 4'h0, 32'h10, 32'h0);
        eval();
        nxt(); eval();
        nxt(); eval(); chk("bw_rd_done", m0_done, 1); chk("bw_rd_byte2", m0_rdata[23:16], 8'hAB);
        nxt();

        // simultaneous requests right after reset
        do_reset();
        issue(0, 4'h0, 32'h4, 32'h0);
        issue(1, 4'h0, 32'h8, 32'h0);
        eval();
        nxt(); eval();
        nxt(); eval(); chk("sim_c2_m0done", m0_done, 1); chk("sim_c2_m1done", m1_done, 0);
        nxt(); eval(); chk("sim_c3_addr", ram_addr, 32'h8); chk("sim_c3_busy", busy, 1);
        nxt(); eval(); chk("sim_c4_m1done", m1_done, 1); chk("sim_c4_cnt", cnt, 3);

        // fairness with both requests held
        do_reset();
        auto_drop = 0;
        issue(0, 4'h0, 32'h4, 32'h0);
        issue(1, 4'h0, 32'h8, 32'h0);
        nd = 0; lastc = -1; cyc = 0;
        while (nd < 10 && cyc < 40) begin
            if (cyc > 0) nxt();
            eval();
            if (m0_done || m1_done) begin
                chk("fair_port", m1_done, nd % 2);
                if (nd > 0) chk("fair_gap", cyc - lastc, 2);
                lastc = cyc;
                nd++;
            end
            cyc++;
        end
        chk("fair_count", nd, 10);
        auto_drop = 1;

        // reset during the ACC of a word write to 0x20
        do_reset();
        old = ram_mem[8];
        issue(0, 4'hF, 32'h20, 32'h1234_5678);
        eval();
        nxt();
        #2;
        chk("rmw_acc_wen", ram_wen, 4'hF);
        resetn = 0;
        #1;
        chk("rmw_wen_drop", ram_wen, 0);
        chk("rmw_busy", busy, 0);
        chk("rmw_done", m0_done, 0);
        m0_req = 0;
        model_reset();
        @(posedge clk); #1;
        chk("rmw_mem", ram_mem[8], old);
        resetn = 1;
        for (int i = 0; i < 4; i++) begin
            eval();
            chk("rmw_no_done", m0_done, 0);
            nxt();
        end
        chk("rmw_idle", busy, 0);
        chk("rmw_cnt", cnt, 0);

        // saturation of the 4-bit counter instance
        do_reset();
        auto_drop = 0;
        issue(0, 4'h0, 32'h4, 32'h0);
        issue(1, 4'h0, 32'h8, 32'h0);
        for (int i = 0; i < 30; i++) begin
            eval();
            nxt();
        end
        eval();
        chk("sat_cnt4", s_cnt, 4'hF);
        nxt();
        auto_drop = 1;

        // random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (!m0_req && $urandom_range(0, 2) == 0) begin
                rw = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
                issue(0, rw, 32'($urandom_range(0, 31)) << 2, $urandom);
            end
            if (!m1_req && $urandom_range(0, 2) == 0) begin
                rw = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
                issue(1, rw, 32'($urandom_range(0, 31)) << 2, $urandom);
            end
            eval();
            nxt();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
